// File: rtl/exec_issue_controller.sv
// Issue controller for the execution stage.
// A register scoreboard holds back decode on RAW/WAW hazards and on execution
// back-pressure. A taken branch from execution turns into a PC redirect and a
// bounded flush window. A level halt request drains outstanding writes and
// then parks issue.
//
// state  | meaning
// RUN    | normal issue
// FLUSH  | flush window after a branch; counter counts the remaining cycles
// DRAIN  | halt requested; no issue, waiting for the scoreboard to empty
// HALTED | drained; stays here while halt_req is held
module exec_issue_controller #(
    parameter int REG_COUNT      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_valid,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd_addr,
    input  logic                      dec_uses_rs1,
    input  logic                      dec_uses_rs2,
    input  logic                      dec_writes_rd,
    input  logic                      ex_stall_output,
    input  logic                      ex_branch,
    input  logic [PC_WIDTH-1:0]       ex_branch_dest_address,
    input  logic                      wb_valid,
    input  logic                      wb_write_register,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                      halt_req,
    output logic                      ex_valid_input,
    output logic                      dec_stall,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [PC_WIDTH-1:0]       redirect_pc,
    output logic                      halted,
    output logic [REG_COUNT-1:0]      pending
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_HALTED} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic                 halted_q;
    logic                 hazard;
    logic                 issue;

    // State register: FSM state, flush counter, scoreboard and halted flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            pending_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            halted_q  <= (state_d == S_HALTED);
        end
    end

    // Next-state logic: FSM transitions, flush countdown and scoreboard update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;

        // Clear first so a same-cycle set on the same register wins: the new
        // writer is still in flight.
        if (wb_valid && wb_write_register) begin
            pending_d[wb_rd_addr] = 1'b0;
        end
        if (issue && dec_writes_rd && (dec_rd_addr != '0)) begin
            pending_d[dec_rd_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (ex_branch) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end else if (halt_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (ex_branch) begin
                    cnt_d = CNT_W'(FLUSH_CYCLES);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DRAIN: begin
                // Looks at the post-writeback scoreboard so the last retire
                // lands in HALTED on the same edge.
                if (!halt_req) begin
                    state_d = S_RUN;
                end else if ((pending_d == '0) && !ex_stall_output) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Output logic: hazard detect, issue strobe, stall, flush and redirect
    always_comb begin
        hazard = (dec_uses_rs1 && (dec_rs1_addr != '0) && pending_q[dec_rs1_addr])
              || (dec_uses_rs2 && (dec_rs2_addr != '0) && pending_q[dec_rs2_addr])
              || (dec_writes_rd && (dec_rd_addr != '0) && pending_q[dec_rd_addr]);

        issue = dec_valid && (state_q == S_RUN) && !hazard && !ex_stall_output
             && !ex_branch && !rst;

        redirect_valid = ex_branch && !rst;
        redirect_pc    = redirect_valid ? ex_branch_dest_address : '0;
        flush          = !rst && (ex_branch || (state_q == S_FLUSH));
        ex_valid_input = issue;
        dec_stall      = rst || (dec_valid && !issue && !flush);
        halted         = halted_q;
        pending        = pending_q;
    end

endmodule

// File: tb/tb_exec_issue_controller.sv
// Directed bench for exec_issue_controller. Combinational outputs are checked
// mid-cycle; the expected scoreboard for each edge is queued when the stimulus
// is applied and compared after the edge.
module tb_exec_issue_controller;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic        dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
    logic        ex_stall_output;
    logic        ex_branch;
    logic [31:0] ex_branch_dest_address;
    logic        wb_valid, wb_write_register;
    logic [4:0]  wb_rd_addr;
    logic        halt_req;
    logic        ex_valid_input, dec_stall, flush, redirect_valid, halted;
    logic [31:0] redirect_pc;
    logic [31:0] pending;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    exec_issue_controller #(
        .REG_COUNT(32), .REG_ADDR_WIDTH(5), .PC_WIDTH(32), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rd_addr(dec_rd_addr), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_writes_rd(dec_writes_rd), .ex_stall_output(ex_stall_output),
        .ex_branch(ex_branch), .ex_branch_dest_address(ex_branch_dest_address),
        .wb_valid(wb_valid), .wb_write_register(wb_write_register), .wb_rd_addr(wb_rd_addr),
        .halt_req(halt_req), .ex_valid_input(ex_valid_input), .dec_stall(dec_stall),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr);
        dec_valid = v; dec_rs1_addr = rs1; dec_uses_rs1 = u1;
        dec_rs2_addr = rs2; dec_uses_rs2 = u2; dec_rd_addr = rd; dec_writes_rd = wr;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        wb_valid = v; wb_write_register = v; wb_rd_addr = rd;
    endtask

    // Move to mid-cycle so combinational outputs have settled.
    task automatic mid();
        #4;
    endtask

    // Queue the scoreboard expected after this edge, cross the edge, compare.
    task automatic edge_pend(input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pending", pending, e);
    endtask

    task automatic chk_issue(input string tag, input logic ev, input logic es);
        chk({tag, ".ex_valid_input"}, {31'd0, ex_valid_input}, {31'd0, ev});
        chk({tag, ".dec_stall"}, {31'd0, dec_stall}, {31'd0, es});
    endtask

    initial begin
        rst = 1'b1; ex_stall_output = 1'b0; ex_branch = 1'b0; ex_branch_dest_address = '0;
        halt_req = 1'b0;
        instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
        wb(1'b0, 5'd0);
        @(posedge clk); #1;

        // reset, cycle 1
        mid();
        chk_issue("rst1", 1'b0, 1'b1);
        chk("rst1.flush", {31'd0, flush}, 32'd0);
        edge_pend(32'h0);
        // reset, cycle 2 with a branch that must be masked
        ex_branch = 1'b1; ex_branch_dest_address = 32'h55;
        mid();
        chk_issue("rst2", 1'b0, 1'b1);
        chk("rst2.flush", {31'd0, flush}, 32'd0);
        chk("rst2.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst2.redirect_pc", redirect_pc, 32'd0);
        edge_pend(32'h0);

        // first independent instruction, writes x5
        rst = 1'b0; ex_branch = 1'b0; ex_branch_dest_address = '0;
        instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        mid();
        chk("post_rst.halted", {31'd0, halted}, 32'd0);
        chk_issue("first", 1'b1, 1'b0);
        edge_pend(32'h0000_0020);

        // RAW on x5
        instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        mid();
        chk_issue("raw", 1'b0, 1'b1);
        edge_pend(32'h0000_0020);
        // writeback x5 this cycle: still stalled
        wb(1'b1, 5'd5);
        mid();
        chk_issue("raw_wb", 1'b0, 1'b1);
        edge_pend(32'h0);
        // W+1: issues
        wb(1'b0, 5'd0);
        mid();
        chk_issue("raw_w1", 1'b1, 1'b0);
        edge_pend(32'h0000_0040);

        // x0 sources and destination, retire x6 meanwhile
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        wb(1'b1, 5'd6);
        mid();
        chk_issue("x0", 1'b1, 1'b0);
        edge_pend(32'h0);

        // issue rd=7 while writeback retires x7: set wins
        instr(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b1);
        wb(1'b1, 5'd7);
        mid();
        chk_issue("simul", 1'b1, 1'b0);
        edge_pend(32'h0000_0080);

        // WAW on x7
        wb(1'b0, 5'd0);
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        mid();
        chk_issue("waw", 1'b0, 1'b1);
        edge_pend(32'h0000_0080);
        // rs2=x7 but unused: issues
        instr(1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 5'd8, 1'b0);
        mid();
        chk_issue("rs2_unused", 1'b1, 1'b0);
        edge_pend(32'h0000_0080);
        // rs2=x7 used: stalls; retire x7
        instr(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0);
        wb(1'b1, 5'd7);
        mid();
        chk_issue("rs2_raw", 1'b0, 1'b1);
        edge_pend(32'h0);

        // execution back-pressure
        wb(1'b0, 5'd0);
        instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1);
        ex_stall_output = 1'b1;
        mid();
        chk_issue("ex_stall", 1'b0, 1'b1);
        edge_pend(32'h0);

        // branch cycle
        ex_stall_output = 1'b0;
        ex_branch = 1'b1; ex_branch_dest_address = 32'h0000_0100;
        mid();
        chk_issue("br0", 1'b0, 1'b0);
        chk("br0.redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("br0.redirect_pc", redirect_pc, 32'h0000_0100);
        chk("br0.flush", {31'd0, flush}, 32'd1);
        edge_pend(32'h0);
        ex_branch = 1'b0; ex_branch_dest_address = 32'h0000_0100;
        mid();
        chk("br1.flush", {31'd0, flush}, 32'd1);
        chk("br1.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("br1.redirect_pc", redirect_pc, 32'd0);
        chk_issue("br1", 1'b0, 1'b0);
        edge_pend(32'h0);
        mid();
        chk("br2.flush", {31'd0, flush}, 32'd1);
        edge_pend(32'h0);
        mid();
        chk("br3.flush", {31'd0, flush}, 32'd0);
        chk_issue("br3", 1'b1, 1'b0);
        edge_pend(32'h0000_0200);

        // branch inside FLUSH reloads the counter
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        ex_branch = 1'b1; ex_branch_dest_address = 32'h200;
        mid();
        edge_pend(32'h0000_0200);
        ex_branch_dest_address = 32'h300;
        mid();
        chk("rl.redirect_pc", redirect_pc, 32'h300);
        edge_pend(32'h0000_0200);
        ex_branch = 1'b0;
        mid();
        chk("rl1.flush", {31'd0, flush}, 32'd1);
        edge_pend(32'h0000_0200);
        mid();
        chk("rl2.flush", {31'd0, flush}, 32'd1);
        edge_pend(32'h0000_0200);
        mid();
        chk("rl3.flush", {31'd0, flush}, 32'd0);

        // halt: x3 in flight, retire x9
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        wb(1'b1, 5'd9);
        mid();
        chk_issue("h_iss", 1'b1, 1'b0);
        edge_pend(32'h0000_0008);
        wb(1'b0, 5'd0);
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        halt_req = 1'b1;
        mid();
        edge_pend(32'h0000_0008);
        instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        mid();
        chk_issue("drain", 1'b0, 1'b1);
        chk("drain.halted", {31'd0, halted}, 32'd0);
        edge_pend(32'h0000_0008);
        wb(1'b1, 5'd3);
        mid();
        chk("drain_w.halted", {31'd0, halted}, 32'd0);
        edge_pend(32'h0);
        wb(1'b0, 5'd0);
        mid();
        chk("w1.halted", {31'd0, halted}, 32'd1);
        chk_issue("halted", 1'b0, 1'b1);
        edge_pend(32'h0);
        halt_req = 1'b0;
        mid();
        chk("rel.halted", {31'd0, halted}, 32'd1);
        edge_pend(32'h0);
        mid();
        chk("resume.halted", {31'd0, halted}, 32'd0);
        chk_issue("resume", 1'b1, 1'b0);
        edge_pend(32'h0000_0010);

        // reset in the middle of FLUSH
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        ex_branch = 1'b1; ex_branch_dest_address = 32'h400;
        mid();
        edge_pend(32'h0000_0010);
        ex_branch = 1'b0;
        rst = 1'b1;
        mid();
        chk("mrst.flush", {31'd0, flush}, 32'd0);
        edge_pend(32'h0);
        rst = 1'b0;
        instr(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        mid();
        chk("after_mrst.flush", {31'd0, flush}, 32'd0);
        chk_issue("after_mrst", 1'b1, 1'b0);
        edge_pend(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
